// File: rtl/compare_pipe.sv
// Two-stage elastic multi-lane integer comparator (EQ/NE/LT/LE/GT/GE, signed or unsigned).
// Optional match counter enabled by defining COMPARE_PIPE_STATS_EN.
module compare_pipe #(
    parameter int N      = 10,
    parameter int LANES  = 1,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*LANES-1:0]   in0,
    input  logic [N*LANES-1:0]   in1,
    input  logic [2:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES-1:0]     out,
    output logic                 out_all,
    output logic                 out_any,
    output logic                 op_err,
    output logic [CNT_W-1:0]     match_cnt,
    input  logic                 stat_clr
);

    logic                 s1_valid_q, s1_valid_d;
    logic [N*LANES-1:0]   s1_a_q, s1_a_d;
    logic [N*LANES-1:0]   s1_b_q, s1_b_d;
    logic [2:0]           s1_op_q, s1_op_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [LANES-1:0]     out_q, out_d;
    logic                 out_all_q, out_all_d;
    logic                 out_any_q, out_any_d;
    logic                 op_err_q, op_err_d;

    logic                 s1_adv;
    logic                 s2_adv;
    logic [LANES-1:0]     lane_eq;
    logic [LANES-1:0]     lane_lt;
    logic [LANES-1:0]     res;

    // A stage may load whenever it is empty or its successor is draining.
    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [N-1:0] a_lane;
            logic [N-1:0] b_lane;
            assign a_lane      = s1_a_q[gi*N +: N];
            assign b_lane      = s1_b_q[gi*N +: N];
            assign lane_eq[gi] = (a_lane == b_lane);
            if (SIGNED != 0) begin : g_signed
                assign lane_lt[gi] = ($signed(a_lane) < $signed(b_lane));
            end else begin : g_unsigned
                assign lane_lt[gi] = (a_lane < b_lane);
            end
        end
    endgenerate

    always_comb begin
        res = '0;
        case (s1_op_q)
            3'd0:    res = lane_eq;
            3'd1:    res = ~lane_eq;
            3'd2:    res = lane_lt;
            3'd3:    res = lane_lt | lane_eq;
            3'd4:    res = ~(lane_lt | lane_eq);
            3'd5:    res = ~lane_lt;
            default: res = '0;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d  = in0;
                s1_b_d  = in1;
                s1_op_d = op;
            end
        end

        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        out_all_d  = out_all_q;
        out_any_d  = out_any_q;
        op_err_d   = op_err_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d     = res;
                out_all_d = &res;
                out_any_d = |res;
                op_err_d  = s1_op_q[2] & s1_op_q[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            out_all_q  <= 1'b0;
            out_any_q  <= 1'b0;
            op_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            out_all_q  <= out_all_d;
            out_any_q  <= out_any_d;
            op_err_q   <= op_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign out_all   = out_all_q;
    assign out_any   = out_any_q;
    assign op_err    = op_err_q;

`ifdef COMPARE_PIPE_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear has priority; the counter sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr) begin
            cnt_d = '0;
        end else if (s2_valid_q & out_ready & out_all_q & ~op_err_q & ~(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign match_cnt       = '0;
`endif

endmodule

// File: tb/tb_compare_pipe.sv
// Bench for compare_pipe: a 4-lane unsigned instance and a 1-lane signed instance share one stream,
// checked against a queue-based reference model; counter checks follow COMPARE_PIPE_STATS_EN.
module tb_compare_pipe;

`ifdef COMPARE_PIPE_STATS_EN
    localparam int SAT_EXP = 3;
`else
    localparam int SAT_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        out_ready;
    logic        stat_clr;
    logic [31:0] in0, in1;
    logic [2:0]  op;

    logic        in_ready, out_valid, out_all, out_any, op_err;
    logic [3:0]  out;
    logic [1:0]  match_cnt;

    logic        s_in_ready, s_out_valid, s_all, s_any, s_err;
    logic [0:0]  s_out;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    compare_pipe #(.N(8), .LANES(4), .SIGNED(0), .CNT_W(2)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_all(out_all), .out_any(out_any), .op_err(op_err),
        .match_cnt(match_cnt), .stat_clr(stat_clr)
    );

    compare_pipe #(.N(8), .LANES(1), .SIGNED(1), .CNT_W(2)) u_sgn (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(s_in_ready),
        .in0(in0[7:0]), .in1(in1[7:0]), .op(op), .out_valid(s_out_valid), .out_ready(out_ready),
        .out(s_out), .out_all(s_all), .out_any(s_any), .op_err(s_err),
        .match_cnt(s_cnt), .stat_clr(stat_clr)
    );

    typedef struct {
        logic [3:0] o;
        logic       all;
        logic       any;
        logic       err;
        logic       so;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_n = 0;
    int   exp_cnt = 0;
    int   exp_scnt = 0;
    bit   chk_lat = 1'b0;
    logic prev_ov = 1'b0;
    logic prev_or = 1'b0;
    logic [7:0] prev_word = '0;

    function automatic int to_i(input logic [7:0] x, input bit sgn);
        if (sgn && x[7]) return int'(x) - 256;
        return int'(x);
    endfunction

    function automatic logic cmp_ref(input int a, input int b, input logic [2:0] o);
        case (o)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return a < b;
            3'd3:    return a <= b;
            3'd4:    return a > b;
            3'd5:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (step %0d)", tag, obs, exp, step_n);
        end
    endtask

    // One clock cycle: drive inputs, check the handshake against the model, retire/accept beats.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] o, input logic ordy, input logic clr,
                        output bit accepted);
        exp_t e;
        logic [3:0] ov;
        @(posedge clk); #1;
        step_n++;
        if (prev_ov && !prev_or) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", {out_all, out_any, op_err, out, s_out}, prev_word);
        end
        in_valid = v; in0 = a; in1 = b; op = o; out_ready = ordy; stat_clr = clr;
        #1;
        chk("in_ready", in_ready, (q.size() < 2) || ordy);
        chk("s_in_ready", s_in_ready, (q.size() < 2) || ordy);
        chk("match_cnt", match_cnt, exp_cnt);
        chk("s_match_cnt", s_cnt, exp_scnt);
        if (q.size() == 0) begin
            chk("no_spurious", out_valid, 1'b0);
            chk("s_no_spurious", s_out_valid, 1'b0);
        end
`ifdef COMPARE_PIPE_STATS_EN
        if (clr) begin
            exp_cnt  = 0;
            exp_scnt = 0;
        end
`endif
        if (out_valid && ordy && q.size() > 0) begin
            e = q.pop_front();
            chk("out", out, e.o);
            chk("out_all", out_all, e.all);
            chk("out_any", out_any, e.any);
            chk("op_err", op_err, e.err);
            chk("s_valid", s_out_valid, 1'b1);
            chk("s_out", s_out, e.so);
            chk("s_op_err", s_err, e.err);
            if (chk_lat) chk("latency", step_n - e.acc, 2);
`ifdef COMPARE_PIPE_STATS_EN
            if (!clr && e.all && !e.err) exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
            if (!clr && e.so && !e.err)  exp_scnt = (exp_scnt < 3) ? exp_scnt + 1 : 3;
`endif
        end
        accepted = v && in_ready;
        if (accepted) begin
            for (int k = 0; k < 4; k++) ov[k] = cmp_ref(to_i(a[k*8 +: 8], 1'b0), to_i(b[k*8 +: 8], 1'b0), o);
            e.o   = ov;
            e.all = (ov == 4'hF);
            e.any = (ov != 4'h0);
            e.err = (o >= 3'd6);
            e.so  = cmp_ref(to_i(a[7:0], 1'b1), to_i(b[7:0], 1'b1), o);
            e.acc = step_n;
            q.push_back(e);
        end
        prev_ov   = out_valid;
        prev_or   = ordy;
        prev_word = {out_all, out_any, op_err, out, s_out};
    endtask

    initial begin
        bit acc;
        int sent;
        logic [31:0] ra, rb;

        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
        in0 = '0; in1 = '0; op = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out", {out_all, out_any, op_err, out}, 7'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cnt", match_cnt, 2'd0);
        chk("rst_s_out_valid", s_out_valid, 1'b0);
        rstn = 1'b1;

        // EQ with identical operands, latency measured from an empty pipe
        chk_lat = 1'b1;
        step(1'b1, {4{8'h5A}}, {4{8'h5A}}, 3'd0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        chk("eq5a_out", out, 4'hF);
        chk("eq5a_s_out", s_out, 1'b1);

        // 0x80 vs 0x7F: unsigned GT true, signed GT false; LE the opposite
        step(1'b1, 32'h80, 32'h7F, 3'd4, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        chk("gt_u_out", out, 4'b0001);
        chk("gt_s_out", s_out, 1'b0);
        step(1'b1, 32'h80, 32'h7F, 3'd3, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        chk("le_u_out", out, 4'b1110);
        chk("le_s_out", s_out, 1'b1);

        // Per-lane EQ: A={1,2,3,4} B={1,0,3,9}
        step(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd9, 8'd3, 8'd0, 8'd1}, 3'd0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        chk("lanes_out", out, 4'b0101);
        chk("lanes_all", out_all, 1'b0);
        chk("lanes_any", out_any, 1'b1);

        // Reserved ops are delivered with op_err and a zero result
        step(1'b1, {4{8'h11}}, {4{8'h11}}, 3'd6, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        chk("op6_err", op_err, 1'b1);
        chk("op6_out", out, 4'h0);
        chk_lat = 1'b0;
        step(1'b1, {4{8'h22}}, {4{8'h22}}, 3'd7, 1'b1, 1'b0, acc);

        // Back-to-back beats at full rate
        for (int i = 0; i < 4; i++)
            step(1'b1, $urandom, $urandom, 3'(i + 2), 1'b1, 1'b0, acc);
        repeat (3) step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);

        // Counter: clear, five all-match beats, then clear racing a match
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 5; i++)
            step(1'b1, {4{8'h33}}, {4{8'h33}}, 3'd0, 1'b1, 1'b0, acc);
        repeat (3) step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        chk("cnt_sat", match_cnt, SAT_EXP);
        step(1'b1, {4{8'h44}}, {4{8'h44}}, 3'd0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, acc);
        step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        chk("cnt_clr_wins", match_cnt, 2'd0);

        // Random stream with 50% downstream backpressure
        sent = 0;
        for (int c = 0; c < 600 && (sent < 20 || q.size() > 0); c++) begin
            ra = $urandom;
            rb = ra ^ ($urandom & $urandom & $urandom);
            step((sent < 20) && ($urandom_range(0, 3) != 0), ra, rb, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), acc);
            if (acc) sent++;
        end
        chk("stream_sent", sent, 20);
        chk("stream_drained", q.size(), 0);

        // Fill both stages, check stall, then reset with beats in flight
        step(1'b1, {4{8'h55}}, {4{8'h55}}, 3'd0, 1'b0, 1'b0, acc);
        step(1'b1, {4{8'h66}}, {4{8'h66}}, 3'd0, 1'b0, 1'b0, acc);
        step(1'b1, {4{8'h77}}, {4{8'h77}}, 3'd0, 1'b0, 1'b0, acc);
        chk("full_stall", acc, 1'b0);
        @(posedge clk); #2;
        chk("pre_rst_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_s_valid", s_out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_out", {out_all, out_any, op_err, out}, 7'd0);
        q.delete();
        exp_cnt = 0; exp_scnt = 0; prev_ov = 1'b0;
        #3;
        rstn = 1'b1;
        repeat (4) step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        step(1'b1, {4{8'h01}}, {4{8'h02}}, 3'd2, 1'b1, 1'b0, acc);
        repeat (3) step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0, acc);
        chk("post_rst_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
